// File: rtl/tmds_pkg.sv
// Shared types, control tokens and bit-count helpers for the DVI TMDS encoder.
// The 8b/10b code is only defined for 8-bit colour components.
package tmds_pkg;

    typedef logic [9:0] tmds_sym_t;

    localparam tmds_sym_t CTRL_00 = 10'b1101010100;
    localparam tmds_sym_t CTRL_01 = 10'b0010101011;
    localparam tmds_sym_t CTRL_10 = 10'b0101010100;
    localparam tmds_sym_t CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
        tmds_sym_t t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 builds the transition-minimised q_m word, stage 2
// picks the DC-balancing polarity (or a control token) and tracks disparity.
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       de,
    input  logic [1:0] c,
    input  logic [7:0] d,
    output tmds_sym_t  sym
);

    logic [3:0] n1_data;
    logic       use_xnor;
    logic [8:0] qm_d;
    logic [3:0] qm_n1_d;
    logic [3:0] qm_n0_d;

    logic [8:0] qm_p1_q;
    logic [3:0] n1_p1_q;
    logic [3:0] n0_p1_q;
    logic       de_p1_q;
    logic [1:0] c_p1_q;

    tmds_sym_t         sym_q;
    tmds_sym_t         sym_d;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;

    logic              qm8;
    logic signed [4:0] n1_s;
    logic signed [4:0] n0_s;
    logic signed [4:0] diff_s;
    logic signed [4:0] two_qm8_s;
    logic signed [4:0] two_nqm8_s;

    assign n1_data  = popcount8(d);
    assign use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !d[0]);

    always_comb begin
        qm_d    = '0;
        qm_d[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d[i]) : (qm_d[i-1] ^ d[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    assign qm_n1_d = popcount8(qm_d[7:0]);
    assign qm_n0_d = 4'd8 - qm_n1_d;

    // ---- stage 1 -> stage 2 boundary ----
    assign qm8        = qm_p1_q[8];
    assign n1_s       = signed'({1'b0, n1_p1_q});
    assign n0_s       = signed'({1'b0, n0_p1_q});
    assign diff_s     = n1_s - n0_s;
    assign two_qm8_s  = signed'({3'b000, qm8, 1'b0});
    assign two_nqm8_s = signed'({3'b000, ~qm8, 1'b0});

    always_comb begin
        sym_d = sym_q;
        cnt_d = cnt_q;
        if (!de_p1_q) begin
            sym_d = ctrl_token(c_p1_q);
            cnt_d = '0;
        end else if ((cnt_q == 5'sd0) || (n1_p1_q == n0_p1_q)) begin
            sym_d = {~qm8, qm8, (qm8 ? qm_p1_q[7:0] : ~qm_p1_q[7:0])};
            cnt_d = qm8 ? (cnt_q + diff_s) : (cnt_q - diff_s);
        end else if (((cnt_q > 5'sd0) && (n1_p1_q > n0_p1_q)) ||
                     ((cnt_q < 5'sd0) && (n0_p1_q > n1_p1_q))) begin
            sym_d = {1'b1, qm8, ~qm_p1_q[7:0]};
            cnt_d = cnt_q + two_qm8_s - diff_s;
        end else begin
            sym_d = {1'b0, qm8, qm_p1_q[7:0]};
            cnt_d = cnt_q + diff_s - two_nqm8_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qm_p1_q <= '0;
            n1_p1_q <= '0;
            n0_p1_q <= '0;
            de_p1_q <= 1'b0;
            c_p1_q  <= '0;
            sym_q   <= CTRL_00;
            cnt_q   <= '0;
        end else if (en) begin
            qm_p1_q <= qm_d;
            n1_p1_q <= qm_n1_d;
            n0_p1_q <= qm_n0_d;
            de_p1_q <= de;
            c_p1_q  <= c;
            // ---- stage 2 output register ----
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sym = sym_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Three-lane DVI TMDS encoder: blue carries {vsync,hsync} during blanking,
// green and red send control token 00. sym_valid marks each new symbol set.
module dvi_tmds_encoder
    import tmds_pkg::*;
#(
    parameter int w_color = 8,
    parameter int w_sym   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               display_on,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [w_color-1:0] red,
    input  logic [w_color-1:0] green,
    input  logic [w_color-1:0] blue,
    output logic [w_sym-1:0]   tmds_red,
    output logic [w_sym-1:0]   tmds_green,
    output logic [w_sym-1:0]   tmds_blue,
    output logic               sym_valid
);

    tmds_sym_t sym_blue;
    tmds_sym_t sym_green;
    tmds_sym_t sym_red;

    logic primed_q;
    logic primed_d;
    logic sym_valid_q;
    logic sym_valid_d;

    tmds_channel_encoder u_ch0 (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .de  (display_on),
        .c   ({vsync, hsync}),
        .d   (blue),
        .sym (sym_blue)
    );

    tmds_channel_encoder u_ch1 (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .de  (display_on),
        .c   (2'b00),
        .d   (green),
        .sym (sym_green)
    );

    tmds_channel_encoder u_ch2 (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .de  (display_on),
        .c   (2'b00),
        .d   (red),
        .sym (sym_red)
    );

    // The first enable after reset only fills stage 1, so it is not flagged.
    assign primed_d    = primed_q | pix_en;
    assign sym_valid_d = pix_en & primed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_q    <= 1'b0;
            sym_valid_q <= 1'b0;
        end else begin
            primed_q    <= primed_d;
            sym_valid_q <= sym_valid_d;
        end
    end

    assign tmds_blue  = sym_blue;
    assign tmds_green = sym_green;
    assign tmds_red   = sym_red;
    assign sym_valid  = sym_valid_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed and random-line bench for dvi_tmds_encoder with an independent
// TMDS reference, symbol decoder and running-disparity bound.
module tb_dvi_tmds_encoder;

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [9:0] tmds_red;
    logic [9:0] tmds_green;
    logic [9:0] tmds_blue;
    logic       sym_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] obs_b, obs_g, obs_r;
    logic [9:0] exp_b, exp_g, exp_r;
    logic       have_prev;
    logic       p_de, p_vs, p_hs;
    logic [7:0] p_r, p_g, p_b;
    int         cnt_b, cnt_g, cnt_r;
    int         sum_b, sum_g, sum_r;

    dvi_tmds_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .display_on (display_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .tmds_red   (tmds_red),
        .tmds_green (tmds_green),
        .tmds_blue  (tmds_blue),
        .sym_valid  (sym_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] q, o;
        q    = s[9] ? ~s[7:0] : s[7:0];
        o[0] = q[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return o;
    endfunction

    // Reference encoder; disparity is advanced from the ones count of the emitted symbol.
    task automatic ref_enc(input logic [7:0] d, input logic de, input logic [1:0] c,
                           inout int cnt, output logic [9:0] s);
        int ones_d, ones_q, zeros_q;
        logic xn;
        logic [7:0] q;
        ones_d = $countones(d);
        xn = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        ones_q  = $countones(q);
        zeros_q = 8 - ones_q;
        if (!de) begin
            s = tok(c);
            cnt = 0;
        end else begin
            if (cnt == 0 || ones_q == zeros_q) s = xn ? {2'b10, ~q} : {2'b01, q};
            else if ((cnt > 0 && ones_q > zeros_q) || (cnt < 0 && zeros_q > ones_q))
                s = {1'b1, ~xn, ~q};
            else s = {1'b0, ~xn, q};
            cnt = cnt + 2 * $countones(s) - 10;
        end
    endtask

    task automatic px(input logic de, input logic vs, input logic hs,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input int gap);
        display_on = de; vsync = vs; hsync = hs;
        red = r; green = g; blue = b;
        pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        obs_b = tmds_blue; obs_g = tmds_green; obs_r = tmds_red;
        if (have_prev) begin
            ref_enc(p_b, p_de, {p_vs, p_hs}, cnt_b, exp_b);
            ref_enc(p_g, p_de, 2'b00, cnt_g, exp_g);
            ref_enc(p_r, p_de, 2'b00, cnt_r, exp_r);
            chk("sym_b", obs_b, exp_b);
            chk("sym_g", obs_g, exp_g);
            chk("sym_r", obs_r, exp_r);
            chk("valid", 10'(sym_valid), 10'd1);
            if (p_de) begin
                chk("dec_b", {2'b00, dec(obs_b)}, {2'b00, p_b});
                chk("dec_g", {2'b00, dec(obs_g)}, {2'b00, p_g});
                chk("dec_r", {2'b00, dec(obs_r)}, {2'b00, p_r});
                sum_b += 2 * $countones(obs_b) - 10;
                sum_g += 2 * $countones(obs_g) - 10;
                sum_r += 2 * $countones(obs_r) - 10;
                chk("disp_b", 10'(sum_b > 10 || sum_b < -10), 10'd0);
                chk("disp_g", 10'(sum_g > 10 || sum_g < -10), 10'd0);
                chk("disp_r", 10'(sum_r > 10 || sum_r < -10), 10'd0);
            end else begin
                sum_b = 0; sum_g = 0; sum_r = 0;
            end
        end else begin
            exp_b = 10'h354; exp_g = 10'h354; exp_r = 10'h354;
            chk("prime_b", obs_b, exp_b);
            chk("prime_g", obs_g, exp_g);
            chk("prime_r", obs_r, exp_r);
            chk("prime_valid", 10'(sym_valid), 10'd0);
        end
        p_de = de; p_vs = vs; p_hs = hs; p_r = r; p_g = g; p_b = b;
        have_prev = 1'b1;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk); #1;
            chk("hold_b", tmds_blue, exp_b);
            chk("hold_g", tmds_green, exp_g);
            chk("hold_r", tmds_red, exp_r);
            chk("valid_idle", 10'(sym_valid), 10'd0);
        end
    endtask

    task automatic clear_model();
        have_prev = 1'b0;
        cnt_b = 0; cnt_g = 0; cnt_r = 0;
        sum_b = 0; sum_g = 0; sum_r = 0;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; display_on = 1'b0;
        hsync = 1'b0; vsync = 1'b0; red = '0; green = '0; blue = '0;
        clear_model();
        p_de = 1'b0; p_vs = 1'b0; p_hs = 1'b0; p_r = '0; p_g = '0; p_b = '0;
        #2;
        chk("rst_b", tmds_blue, 10'h354);
        chk("rst_g", tmds_green, 10'h354);
        chk("rst_r", tmds_red, 10'h354);
        chk("rst_valid", 10'(sym_valid), 10'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero pixels from cnt 0, then blanking, then 0xFF from cnt 0, then sync tokens.
        px(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        px(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        chk("t2_b0", obs_b, 10'h100);
        px(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        chk("t2_b1", obs_b, 10'h3FF);
        px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        chk("t2_b2", obs_b, 10'h100);
        chk("t2_g2", obs_g, 10'h100);
        px(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 0);
        chk("t4_b00", obs_b, 10'h354);
        px(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 0);
        chk("t3_bff", obs_b, 10'h200);
        px(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        chk("t4_b01", obs_b, 10'h0AB);
        chk("t4_g01", obs_g, 10'h354);
        chk("t4_r01", obs_r, 10'h354);
        px(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 0);
        chk("t4_b10", obs_b, 10'h154);
        px(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        chk("t4_b11", obs_b, 10'h2AB);
        chk("t4_r11", obs_r, 10'h354);
        px(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        chk("t4_cnt0", obs_b, 10'h100);

        // Sparse enables: symbols and disparity must hold across idle clocks.
        for (int i = 0; i < 6; i++)
            px(1'b1, 1'b0, 1'b0, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
               8'($urandom_range(255, 0)), 7);

        // Asynchronous reset in the middle of a line.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_b", tmds_blue, 10'h354);
        chk("mid_rst_g", tmds_green, 10'h354);
        chk("mid_rst_r", tmds_red, 10'h354);
        chk("mid_rst_valid", 10'(sym_valid), 10'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        px(1'b1, 1'b0, 1'b0, 8'h5A, 8'hC3, 8'h0F, 1);
        px(1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hF0, 1);
        px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1);

        // One full active line of random RGB followed by blanking.
        for (int i = 0; i < 640; i++)
            px(1'b1, 1'b0, 1'b0, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
               8'($urandom_range(255, 0)), 0);
        px(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        px(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_tmds_encoder.md
Name: dvi_tmds_encoder

Overview:
Converts the 24-bit RGB pixel stream, plus hsync, vsync and display_on from the vga timing stage, into three 10-bit TMDS symbols (blue/ch0, green/ch1, red/ch2).
- Uses the DVI 1.0 transition-minimised, DC-balanced 8b/10b code.
- Sits between the vga timing generator and the 10:1 serializer/differential output stage of the DVI transmitter path.
- Runs on the serial clock domain and advances only on the one-cycle pixel enable.

Parameters:
w_color, 8, bits per colour component; fixed at 8 (encoder is defined only for 8).
w_sym, 10, TMDS symbol width.

Ports:
clk  input  1  serial/system clock (same net that drives vga).
rst  input  1  asynchronous, active-high reset.
pix_en  input  1  one-cycle strobe per pixel; pipeline advances only when high.
display_on  input  1  data enable (DE) from vga.
hsync  input  1  horizontal sync, polarity as delivered to the transmitter.
vsync  input  1  vertical sync, polarity as delivered to the transmitter.
red  input  8  pixel red.
green  input  8  pixel green.
blue  input  8  pixel blue.
tmds_red  output  10  ch2 symbol.
tmds_green  output  10  ch1 symbol.
tmds_blue  output  10  ch0 symbol.
sym_valid  output  1  high for one clk when new symbols are presented (delayed pix_en).

Behaviour:
- Reset, applied asynchronously while rst=1:
  - all tmds_* outputs = 10'b1101010100 (control token C=00);
  - all disparity counters = 0;
  - all pipeline regs = 0;
  - sym_valid = 0.
- Pipeline: 2 stages, both gated by pix_en. Input sampled on pix_en edge n appears on tmds_* after pix_en edge n+1. sym_valid = pix_en delayed by 1 clk once the first stage is primed. Outputs hold between enables.
- Stage 1, per channel: compute N1(D).
  - If N1>4, or N1==4 with D[0]==0: XNOR chain, q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - q_m[0]=D[0]; q_m[i]=q_m[i-1] op D[i].
  - Register q_m[8:0], N1/N0 of q_m[7:0], de, and control bits.
- Stage 2, de=1 (cnt is 5-bit signed; range stays within ±10):
  - Branch A, when cnt==0 or N1==N0:
    - out={~q_m8, q_m8, q_m8 ? q_m : ~q_m};
    - cnt += q_m8 ? (N1-N0) : (N0-N1).
  - Branch B, when (cnt>0 & N1>N0) or (cnt<0 & N0>N1):
    - out={1, q_m8, ~q_m};
    - cnt += 2*q_m8 + N0 - N1.
  - Branch C, otherwise:
    - out={0, q_m8, q_m};
    - cnt += N1 - N0 - 2*(~q_m8).
- Stage 2, de=0:
  - out = control token, cnt forced to 0.
  - Tokens: C=00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - ch0 C={vsync,hsync}; ch1, ch2 C=00 (no DVI preambles).
- de toggling between consecutive pixels needs no idle cycle: each symbol uses its own registered de.
- pix_en low: no state change, including cnt.
- Reset mid-line: outputs revert to token 00 immediately and cnt clears. First valid symbol follows two enables after release.

Decomposition:
- Package tmds_pkg holds:
  - typedef tmds_sym_t (logic [9:0]);
  - constants CTRL_00, CTRL_01, CTRL_10, CTRL_11;
  - function popcount8.
- Sub-module tmds_channel_encoder (clk, rst, en, de, c[1:0], d[7:0] → sym[9:0]) holds the two-stage pipeline and cnt.
- Top instantiates three channel encoders and the sym_valid delay.

Test Plan:
1. Reset: rst=1 asserted mid-stream → all tmds_* = 0x354 (1101010100) within the same cycle, sym_valid=0; after release and two pix_en, symbols track inputs.
2. Blue 0x00 ×3 with de=1 from cnt=0 → 0x100, 0x3FF, 0x100; internal cnt −8, +2, −6.
3. Blue 0xFF with de=1, cnt=0 → 0x200, cnt −8.
4. de=0 with {vsync,hsync}=00/01/10/11 → tmds_blue 0x354/0x0AB/0x154/0x2AB; tmds_green and tmds_red stay 0x354; cnt cleared to 0 on the next de=1 pixel.
5. pix_en held low 7 clks between pixels → outputs and cnt unchanged; sym_valid pulses exactly once per pix_en, one clk later.
6. Random RGB over 640 active pixels vs reference model → exact match; a TMDS decode of each symbol returns the input byte; cumulative disparity stays within ±10 over the line.
